// File: rtl/block_move_ctrl.sv
// Per-frame move scheduler: priority key select, press/auto-repeat timing,
// periodic gravity merged into a single registered keycode pulse per frame.
`timescale 1ns/1ps
module block_move_ctrl #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned DAS_DELAY     = 8,
  parameter int unsigned REPEAT_PERIOD = 3,
  parameter int unsigned DROP_PERIOD   = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       pause,
  output logic [7:0] move_keycode,
  output logic       move_valid,
  output logic       drop_tick,
  output logic [1:0] rpt_state
);

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_W    = 8'h1A;

  localparam logic [CNT_W-1:0] DAS_LAST  = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_t;

  rpt_t             state, state_nx;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nx;
  logic [CNT_W-1:0] drop_cnt;
  logic [7:0]       prev_key;
  logic [7:0]       sel;
  logic             grav_pend;
  logic             key_emit;
  logic             grav_ev;

  function automatic logic is_dir(input logic [7:0] k);
    return (k == KEY_A) || (k == KEY_D) || (k == KEY_S) || (k == KEY_W);
  endfunction

  always_comb begin
    sel = KEY_NONE;
    if (is_dir(keycode0))      sel = keycode0;
    else if (is_dir(keycode1)) sel = keycode1;
  end

  assign grav_ev = (drop_cnt == DROP_LAST);

  always_comb begin
    key_emit   = 1'b0;
    state_nx   = state;
    rpt_cnt_nx = rpt_cnt;
    if (sel == KEY_NONE) begin
      state_nx   = IDLE;
      rpt_cnt_nx = '0;
    end else if (sel != prev_key) begin
      key_emit   = 1'b1;
      state_nx   = DELAY;
      rpt_cnt_nx = '0;
    end else begin
      case (state)
        DELAY: begin
          if (rpt_cnt == DAS_LAST) begin
            key_emit   = 1'b1;
            state_nx   = REPEAT;
            rpt_cnt_nx = '0;
          end else begin
            rpt_cnt_nx = rpt_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (rpt_cnt == REP_LAST) begin
            key_emit   = 1'b1;
            rpt_cnt_nx = '0;
          end else begin
            rpt_cnt_nx = rpt_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      rpt_cnt      <= '0;
      drop_cnt     <= '0;
      prev_key     <= KEY_NONE;
      grav_pend    <= 1'b0;
      move_keycode <= KEY_NONE;
      move_valid   <= 1'b0;
      drop_tick    <= 1'b0;
    end else if (pause) begin
      move_keycode <= KEY_NONE;
      move_valid   <= 1'b0;
      drop_tick    <= 1'b0;
    end else begin
      state    <= state_nx;
      rpt_cnt  <= rpt_cnt_nx;
      prev_key <= sel;
      drop_cnt <= grav_ev ? '0 : drop_cnt + CNT_W'(1);
      // Key emission wins the frame; a colliding gravity event waits one-deep.
      if (key_emit) begin
        move_keycode <= sel;
        move_valid   <= 1'b1;
        drop_tick    <= 1'b0;
        if (grav_ev) grav_pend <= 1'b1;
      end else if (grav_ev || grav_pend) begin
        move_keycode <= KEY_S;
        move_valid   <= 1'b1;
        drop_tick    <= 1'b1;
        grav_pend    <= 1'b0;
      end else begin
        move_keycode <= KEY_NONE;
        move_valid   <= 1'b0;
        drop_tick    <= 1'b0;
      end
    end
  end

  assign rpt_state = state;

endmodule

// File: tb/tb_block_move_ctrl.sv
// Bench for block_move_ctrl: frame-age/gravity-count model checked every edge,
// plus directed literal expectations from the scheduling scenarios.
`timescale 1ns/1ps
module tb_block_move_ctrl;

  localparam int DAS  = 8;
  localparam int RP   = 3;
  localparam int DROP = 30;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode0, keycode1;
  logic       pause;
  logic [7:0] move_keycode;
  logic       move_valid, drop_tick;
  logic [1:0] rpt_state;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Model: key age in non-paused frames since its press, gravity frame count.
  logic [7:0] m_prev;
  int         m_age;
  int         m_f;
  bit         m_pend;

  block_move_ctrl #(
    .CNT_W(8), .DAS_DELAY(DAS), .REPEAT_PERIOD(RP), .DROP_PERIOD(DROP)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode0(keycode0), .keycode1(keycode1),
    .pause(pause), .move_keycode(move_keycode), .move_valid(move_valid),
    .drop_tick(drop_tick), .rpt_state(rpt_state)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  function automatic logic [7:0] sel_of(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h04 || a == 8'h07 || a == 8'h16 || a == 8'h1A) return a;
    if (b == 8'h04 || b == 8'h07 || b == 8'h16 || b == 8'h1A) return b;
    return 8'h00;
  endfunction

  always @(posedge frame_clk or posedge Reset) begin
    logic [7:0] s, e_code;
    logic       e_drop, emit, gev;
    logic [1:0] e_state;
    if (Reset) begin
      m_prev = 8'h00; m_age = 0; m_f = 0; m_pend = 0; edge_n = 0;
      #1;
      chk("rst_code", move_keycode, 8'h00);
      chk("rst_valid", move_valid, 1'b0);
      chk("rst_drop", drop_tick, 1'b0);
      chk("rst_state", rpt_state, 2'd0);
    end else begin
      edge_n++;
      e_code = 8'h00; e_drop = 1'b0;
      if (!pause) begin
        s    = sel_of(keycode0, keycode1);
        emit = 1'b0;
        if (s == 8'h00) m_age = 0;
        else if (s != m_prev) begin emit = 1'b1; m_age = 0; end
        else begin
          m_age++;
          emit = (m_age == DAS) || (m_age > DAS && (m_age - DAS) % RP == 0);
        end
        m_prev = s;
        m_f++;
        gev = (m_f % DROP == 0);
        if (emit) begin
          e_code = s;
          if (gev) m_pend = 1;
        end else if (gev || m_pend) begin
          e_code = 8'h16; e_drop = 1'b1; m_pend = 0;
        end
      end
      e_state = (m_prev == 8'h00) ? 2'd0 : (m_age < DAS) ? 2'd1 : 2'd2;
      #1;
      chk("code", move_keycode, e_code);
      chk("valid", move_valid, e_code != 8'h00);
      chk("drop", drop_tick, e_drop);
      chk("state", rpt_state, e_state);
    end
  end

  task automatic finish_summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  task automatic at_edge(input int k);
    int guard = 0;
    while (edge_n < k) begin
      @(posedge frame_clk); #2;
      guard++;
      if (guard > 500) begin
        n_fail++;
        $display("FAIL at_edge timeout waiting for edge %0d (now %0d)", k, edge_n);
        finish_summary();
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic lit(input int k, input string nm, input logic [7:0] code,
                     input logic drop, input logic [1:0] st);
    at_edge(k);
    chk({nm, "_code"}, move_keycode, code);
    chk({nm, "_drop"}, drop_tick, drop);
    chk({nm, "_state"}, rpt_state, st);
  endtask

  task automatic set_after(input int k, input logic [7:0] a, input logic [7:0] b);
    at_edge(k);
    @(negedge frame_clk);
    keycode0 = a; keycode1 = b;
  endtask

  task automatic do_reset();
    keycode0 = 8'h00; keycode1 = 8'h00; pause = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; keycode0 = 8'h00; keycode1 = 8'h00; pause = 1'b0;
    #1;
    do_reset();

    // Gravity alone
    lit(29, "g29", 8'h00, 1'b0, 2'd0);
    lit(30, "g30", 8'h16, 1'b1, 2'd0);
    lit(31, "g31", 8'h00, 1'b0, 2'd0);
    lit(60, "g60", 8'h16, 1'b1, 2'd0);
    at_edge(65);

    // Press and auto-repeat, then collision with gravity
    do_reset();
    set_after(4, 8'h04, 8'h00);
    lit(5,  "p5",  8'h04, 1'b0, 2'd1);
    lit(6,  "p6",  8'h00, 1'b0, 2'd1);
    lit(13, "p13", 8'h04, 1'b0, 2'd2);
    lit(16, "p16", 8'h04, 1'b0, 2'd2);
    lit(19, "p19", 8'h04, 1'b0, 2'd2);
    lit(22, "p22", 8'h04, 1'b0, 2'd2);
    set_after(22, 8'h00, 8'h00);
    lit(23, "rel", 8'h00, 1'b0, 2'd0);
    set_after(29, 8'h07, 8'h00);
    lit(30, "col30", 8'h07, 1'b0, 2'd1);
    lit(31, "col31", 8'h16, 1'b1, 2'd1);
    set_after(32, 8'h00, 8'h00);

    // Priority and key change mid-repeat
    set_after(34, 8'h07, 8'h04);
    lit(35, "pri07", 8'h07, 1'b0, 2'd1);
    set_after(35, 8'h2C, 8'h1A);
    lit(36, "pri1A", 8'h1A, 1'b0, 2'd1);
    set_after(36, 8'h2C, 8'h00);
    lit(37, "pri00", 8'h00, 1'b0, 2'd0);
    set_after(37, 8'h04, 8'h00);
    lit(46, "r46", 8'h04, 1'b0, 2'd2);
    set_after(50, 8'h07, 8'h00);
    lit(51, "chg51", 8'h07, 1'b0, 2'd1);
    lit(59, "chg59", 8'h07, 1'b0, 2'd2);
    lit(60, "grav60", 8'h16, 1'b1, 2'd2);
    lit(62, "chg62", 8'h07, 1'b0, 2'd2);
    set_after(62, 8'h00, 8'h00);

    // Pause mid-DELAY
    set_after(64, 8'h04, 8'h00);
    at_edge(68);
    @(negedge frame_clk); pause = 1'b1;
    lit(70, "pz70", 8'h00, 1'b0, 2'd1);
    lit(78, "pz78", 8'h00, 1'b0, 2'd1);
    @(negedge frame_clk); pause = 1'b0;
    lit(82, "pz82", 8'h00, 1'b0, 2'd1);
    lit(83, "pz83", 8'h04, 1'b0, 2'd2);
    lit(90, "pz90", 8'h00, 1'b0, 2'd2);
    lit(100, "pz100", 8'h16, 1'b1, 2'd2);

    // Asynchronous reset mid-repeat with key still held
    at_edge(105);
    #1 Reset = 1'b1;
    #1;
    chk("arst_code", move_keycode, 8'h00);
    chk("arst_valid", move_valid, 1'b0);
    chk("arst_state", rpt_state, 2'd0);
    repeat (2) @(negedge frame_clk);
    Reset = 1'b0;
    lit(1, "rp1", 8'h04, 1'b0, 2'd1);
    lit(9, "rp9", 8'h04, 1'b0, 2'd2);
    at_edge(12);

    finish_summary();
    $finish;
  end

endmodule
